wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage consuming the registered MEM/WB pipeline outputs (`wb_*` bus) and turning them into architectural state updates. It does the following:
- Aligns and extends load data.
- Drives the GPR write port and the CP0 write port.
- Owns the HI/LO registers.
- Optionally records retired GPR writes in a small trace FIFO with a valid/ready drain port.

## Interface
Parameters:
- TRACE_DEPTH, 4, trace FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb_memtype  in  8  one-hot access type: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW
- wb_mreg  in  1  1 = GPR data from memory, 0 = from wb_dreg
- wb_whilo  in  2  [1] write HI, [0] write LO
- wb_wreg  in  1  GPR write request
- wb_wa  in  5  GPR destination
- wb_dreg  in  32  ALU/move result
- wb_hilo  in  64  {HI,LO} result from mult/div
- wb_dre  in  4  byte enables of the access
- wb_pc  in  32  instruction PC
- wb_is_mthilo  in  2  [1] MTHI, [0] MTLO (source = wb_dreg)
- wb_wc0  in  1  CP0 write request
- wb_cp0addr  in  5  CP0 register
- wb_cp0wdata  in  32  CP0 write data
- wb_daddr  in  32  data address
- dm_rdata  in  32  data-memory read word, valid in WB cycle
- rf_we  out  1  GPR write enable
- rf_wa  out  5  GPR write address
- rf_wd  out  32  GPR write data
- hi_o, lo_o  out  32 each  HI/LO register contents
- cp0_we  out  1  CP0 write enable
- cp0_waddr  out  5  CP0 write address
- cp0_wdata  out  32  CP0 write data
- trace_valid  out  1  trace head valid
- trace_pc  out  32  trace head PC
- trace_wa  out  5  trace head destination
- trace_wd  out  32  trace head data
- trace_ready  in  1  consumer accepts head
- trace_overflow  out  1  sticky: a trace entry was dropped

## Operation
- Load extraction, little-endian, with b = wb_daddr[1:0]:
  - LB/LBU select dm_rdata byte b.
  - LH/LHU select halfword b[1]. b[0] is ignored; alignment is checked upstream.
  - LW passes dm_rdata through.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other memtype with wb_mreg = 1 yields dm_rdata unmodified.
- GPR port, combinational:
  - rf_we = wb_wreg & (wb_wa ≠ 0).
  - rf_wa = wb_wa.
  - rf_wd = wb_mreg ? load data : wb_dreg.
- CP0 port, combinational pass-through: cp0_we = wb_wc0, cp0_waddr = wb_cp0addr, cp0_wdata = wb_cp0wdata.
- HI/LO registers, updated at the clock edge:
  - If wb_whilo[1], HI <= wb_is_mthilo[1] ? wb_dreg : wb_hilo[63:32].
  - If wb_whilo[0], LO <= wb_is_mthilo[0] ? wb_dreg : wb_hilo[31:0].
  - Bits are independent. A bubble (all zero) holds both registers.
- Trace FIFO:
  - Each cycle with rf_we = 1 pushes {wb_pc, rf_wa, rf_wd}.
  - Pop occurs on trace_valid & trace_ready.
  - trace_valid = not empty. The head fields are driven from storage and are stable while trace_valid & !trace_ready.
  - Full with push and no pop: the entry is dropped and trace_overflow is set. It stays set until reset.
  - Full with push and pop in the same cycle: both occur, no drop, count unchanged.
  - Empty with push: the entry becomes visible the next cycle. There is no fall-through.
  - Pointers wrap modulo TRACE_DEPTH. Count width is log2(TRACE_DEPTH)+1.

## Timing
- GPR and CP0 ports: 0-cycle latency from wb_* and dm_rdata.
- HI/LO: visible on hi_o/lo_o one cycle after the write cycle. No internal bypass; the forwarding network uses wb_hilo/wb_dreg.
- Trace: push to trace_valid takes 1 cycle. Maximum throughput is 1 entry per cycle.
- Reset (resetn = 0 at posedge) forces:
  - hi_o = lo_o = 0.
  - FIFO empty, so trace_valid = 0.
  - trace_overflow = 0.
  - trace_pc/wa/wd = 0.
- Reset wins over a simultaneous push or pop.
- Combinational outputs follow their inputs during reset. The upstream register already presents zeros during reset, so rf_we = cp0_we = 0.

## Configuration
- WB_TRACE_EN defined: trace FIFO built as above.
- WB_TRACE_EN undefined: no FIFO storage. trace_valid, trace_pc, trace_wa, trace_wd and trace_overflow are tied to 0, and trace_ready is ignored. All ports remain present.

## Test plan
- LB, daddr = 0x…3, dm_rdata = 0x80112233, wb_mreg = 1, wb_wreg = 1, wa = 5 -> rf_we = 1, rf_wd = 0xFFFFFF80. The same access as LBU -> rf_wd = 0x00000080.
- LH, daddr = 0x…2, dm_rdata = 0x9ABC1234 -> rf_wd = 0xFFFF9ABC. LHU -> 0x00009ABC. wb_wa = 0 with wb_wreg = 1 -> rf_we = 0 and no trace push.
- MULT: whilo = 11, hilo = 0x00000001_FFFFFFFE -> next cycle hi_o = 1, lo_o = 0xFFFFFFFE. MTLO: dreg = 0x55, whilo = 01, is_mthilo = 01 -> lo_o = 0x55 and hi_o unchanged.
- WB_TRACE_EN, trace_ready = 0, 5 consecutive GPR writes, TRACE_DEPTH = 4 -> 4 entries held, the 5th dropped, trace_overflow = 1. Raise ready -> the first 4 PCs drain in order, one per cycle.
- FIFO full, push with trace_ready = 1 in the same cycle -> no drop, trace_overflow stays 0, valid stays 1.
- Assert resetn = 0 mid-drain with 3 entries queued -> next cycle trace_valid = 0, hi_o = lo_o = 0, trace_overflow = 0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Extracts load data, drives the GPR and CP0 write
// ports, holds HI/LO, and (with WB_TRACE_EN defined) keeps a small FIFO of
// retired GPR writes drained through a valid/ready port.
module wb_stage #(
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  wb_memtype,
    input  logic        wb_mreg,
    input  logic [1:0]  wb_whilo,
    input  logic        wb_wreg,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_dreg,
    input  logic [63:0] wb_hilo,
    input  logic [3:0]  wb_dre,
    input  logic [31:0] wb_pc,
    input  logic [1:0]  wb_is_mthilo,
    input  logic        wb_wc0,
    input  logic [4:0]  wb_cp0addr,
    input  logic [31:0] wb_cp0wdata,
    input  logic [31:0] wb_daddr,
    input  logic [31:0] dm_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_wa,
    output logic [31:0] trace_wd,
    input  logic        trace_ready,
    output logic        trace_overflow
);

    localparam int unsigned AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // Select and extend the addressed byte/halfword of the read word.
    always_comb begin
        ld_byte   = '0;
        ld_half   = '0;
        load_data = dm_rdata;
        case (wb_daddr[1:0])
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = wb_daddr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        if (wb_memtype[0])
            load_data = {{24{ld_byte[7]}}, ld_byte};
        else if (wb_memtype[1])
            load_data = {24'h0, ld_byte};
        else if (wb_memtype[2])
            load_data = {{16{ld_half[15]}}, ld_half};
        else if (wb_memtype[3])
            load_data = {16'h0, ld_half};
        else if (wb_memtype[4])
            load_data = dm_rdata;
        else
            load_data = dm_rdata;
    end

    assign rf_we     = wb_wreg & (wb_wa != 5'd0);
    assign rf_wa     = wb_wa;
    assign rf_wd     = wb_mreg ? load_data : wb_dreg;

    assign cp0_we    = wb_wc0;
    assign cp0_waddr = wb_cp0addr;
    assign cp0_wdata = wb_cp0wdata;

    // HI/LO registers; each half written independently, MTHI/MTLO take wb_dreg.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (wb_whilo[1])
                hi_r <= wb_is_mthilo[1] ? wb_dreg : wb_hilo[63:32];
            if (wb_whilo[0])
                lo_r <= wb_is_mthilo[0] ? wb_dreg : wb_hilo[31:0];
        end
    end

    assign hi_o = hi_r;
    assign lo_o = lo_r;

`ifdef WB_TRACE_EN
    localparam logic [AW:0] FULL_CNT = TRACE_DEPTH[AW:0];

    logic [31:0]   q_pc [TRACE_DEPTH];
    logic [4:0]    q_wa [TRACE_DEPTH];
    logic [31:0]   q_wd [TRACE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf_r;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (count == FULL_CNT);
    assign pop     = (count != '0) & trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = rf_we & (~full | pop);

    // Trace FIFO storage, pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_r  <= 1'b0;
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
                q_pc[i] <= '0;
                q_wa[i] <= '0;
                q_wd[i] <= '0;
            end
        end else begin
            if (do_push) begin
                q_pc[wr_ptr] <= wb_pc;
                q_wa[wr_ptr] <= rf_wa;
                q_wd[wr_ptr] <= rf_wd;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~pop)
                count <= count + (AW+1)'(1);
            else if (~do_push & pop)
                count <= count - (AW+1)'(1);
            if (rf_we & full & ~pop)
                ovf_r <= 1'b1;
        end
    end

    assign trace_valid    = (count != '0);
    assign trace_pc       = q_pc[rd_ptr];
    assign trace_wa       = q_wa[rd_ptr];
    assign trace_wd       = q_wd[rd_ptr];
    assign trace_overflow = ovf_r;

    logic unused_ok;
    assign unused_ok = ^{wb_memtype[7:5], wb_dre, wb_daddr[31:2]};
`else
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_wa       = '0;
    assign trace_wd       = '0;
    assign trace_overflow = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{wb_memtype[7:5], wb_dre, wb_daddr[31:2], wb_pc, trace_ready};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a queue-based
// reference model. Trace expectations follow whether WB_TRACE_EN is defined.
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic [7:0]  wb_memtype;
    logic        wb_mreg;
    logic [1:0]  wb_whilo;
    logic        wb_wreg;
    logic [4:0]  wb_wa;
    logic [31:0] wb_dreg;
    logic [63:0] wb_hilo;
    logic [3:0]  wb_dre;
    logic [31:0] wb_pc;
    logic [1:0]  wb_is_mthilo;
    logic        wb_wc0;
    logic [4:0]  wb_cp0addr;
    logic [31:0] wb_cp0wdata;
    logic [31:0] wb_daddr;
    logic [31:0] dm_rdata;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_wa;
    logic [31:0] trace_wd;
    logic        trace_ready;
    logic        trace_overflow;

    localparam int DEPTH = 4;
`ifdef WB_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] mq_pc[$];
    logic [4:0]  mq_wa[$];
    logic [31:0] mq_wd[$];
    logic        m_ovf = 1'b0;
    logic        m_clean = 1'b1;

    wb_stage #(.TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .wb_memtype(wb_memtype), .wb_mreg(wb_mreg),
        .wb_whilo(wb_whilo), .wb_wreg(wb_wreg), .wb_wa(wb_wa), .wb_dreg(wb_dreg),
        .wb_hilo(wb_hilo), .wb_dre(wb_dre), .wb_pc(wb_pc), .wb_is_mthilo(wb_is_mthilo),
        .wb_wc0(wb_wc0), .wb_cp0addr(wb_cp0addr), .wb_cp0wdata(wb_cp0wdata),
        .wb_daddr(wb_daddr), .dm_rdata(dm_rdata), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .hi_o(hi_o), .lo_o(lo_o), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_wa(trace_wa), .trace_wd(trace_wd), .trace_ready(trace_ready),
        .trace_overflow(trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [7:0] mt, input logic [1:0] b,
                                             input logic [31:0] w);
        logic [7:0]  by;
        logic [15:0] hw;
        by = 8'((w >> (int'(b) * 8)) & 32'hFF);
        hw = b[1] ? w[31:16] : w[15:0];
        if (mt[0]) return 32'($signed(by));
        if (mt[1]) return {24'h0, by};
        if (mt[2]) return 32'($signed(hw));
        if (mt[3]) return {16'h0, hw};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        resetn = 1'b1; wb_memtype = '0; wb_mreg = 1'b0; wb_whilo = '0; wb_wreg = 1'b0;
        wb_wa = '0; wb_dreg = '0; wb_hilo = '0; wb_dre = '0; wb_pc = '0; wb_is_mthilo = '0;
        wb_wc0 = 1'b0; wb_cp0addr = '0; wb_cp0wdata = '0; wb_daddr = '0; dm_rdata = '0;
    endtask

    task automatic gpr_write(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] d);
        set_idle();
        wb_wreg = 1'b1; wb_wa = wa; wb_dreg = d; wb_pc = pc;
    endtask

    // Check all outputs against the model, advance one clock, advance the model.
    task automatic cycle();
        logic        e_we;
        logic [31:0] e_wd;
        logic        valid;
        logic        pop;
        #1;
        e_we = wb_wreg && (wb_wa != 5'd0);
        e_wd = wb_mreg ? ref_load(wb_memtype, wb_daddr[1:0], dm_rdata) : wb_dreg;
        chk("rf_we", 64'(rf_we), 64'(e_we));
        chk("rf_wa", 64'(rf_wa), 64'(wb_wa));
        chk("rf_wd", 64'(rf_wd), 64'(e_wd));
        chk("cp0_we", 64'(cp0_we), 64'(wb_wc0));
        chk("cp0_waddr", 64'(cp0_waddr), 64'(wb_cp0addr));
        chk("cp0_wdata", 64'(cp0_wdata), 64'(wb_cp0wdata));
        chk("hi_o", 64'(hi_o), 64'(m_hi));
        chk("lo_o", 64'(lo_o), 64'(m_lo));
        valid = TR && (mq_pc.size() > 0);
        chk("trace_valid", 64'(trace_valid), 64'(valid));
        chk("trace_overflow", 64'(trace_overflow), 64'(TR && m_ovf));
        if (valid) begin
            chk("trace_pc", 64'(trace_pc), 64'(mq_pc[0]));
            chk("trace_wa", 64'(trace_wa), 64'(mq_wa[0]));
            chk("trace_wd", 64'(trace_wd), 64'(mq_wd[0]));
        end else if (m_clean || !TR) begin
            chk("trace_head_zero", {27'h0, trace_wa, trace_pc}, 64'h0);
            chk("trace_wd_zero", 64'(trace_wd), 64'h0);
        end
        // model update at the edge
        pop = valid && trace_ready;
        if (!resetn) begin
            m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_clean = 1'b1;
            mq_pc.delete(); mq_wa.delete(); mq_wd.delete();
        end else begin
            if (wb_whilo[1]) m_hi = wb_is_mthilo[1] ? wb_dreg : wb_hilo[63:32];
            if (wb_whilo[0]) m_lo = wb_is_mthilo[0] ? wb_dreg : wb_hilo[31:0];
            if (e_we && mq_pc.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
            end else begin
                if (pop) begin
                    void'(mq_pc.pop_front()); void'(mq_wa.pop_front()); void'(mq_wd.pop_front());
                end
                if (e_we) begin
                    mq_pc.push_back(wb_pc); mq_wa.push_back(wb_wa); mq_wd.push_back(e_wd);
                    m_clean = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        resetn = 1'b0;
        trace_ready = 1'b0;
        @(posedge clk); #1;
        cycle();

        // loads, trace drained as it fills
        trace_ready = 1'b1;
        set_idle();
        wb_memtype = 8'h01; wb_daddr = 32'h1003; dm_rdata = 32'h80112233;
        wb_mreg = 1'b1; wb_wreg = 1'b1; wb_wa = 5'd5; wb_pc = 32'h100;
        #1 chk("lb_wd", 64'(rf_wd), 64'hFFFFFF80);
        chk("lb_we", 64'(rf_we), 64'h1);
        cycle();
        wb_memtype = 8'h02; wb_pc = 32'h104;
        #1 chk("lbu_wd", 64'(rf_wd), 64'h00000080);
        cycle();
        wb_memtype = 8'h04; wb_daddr = 32'h2002; dm_rdata = 32'h9ABC1234; wb_pc = 32'h108;
        #1 chk("lh_wd", 64'(rf_wd), 64'hFFFF9ABC);
        cycle();
        wb_memtype = 8'h08; wb_pc = 32'h10C;
        #1 chk("lhu_wd", 64'(rf_wd), 64'h00009ABC);
        cycle();
        wb_wa = 5'd0; wb_pc = 32'h110;
        #1 chk("wa0_we", 64'(rf_we), 64'h0);
        cycle();

        // HI/LO
        set_idle();
        wb_whilo = 2'b11; wb_hilo = 64'h00000001_FFFFFFFE;
        cycle();
        set_idle();
        wb_whilo = 2'b01; wb_is_mthilo = 2'b01; wb_dreg = 32'h55;
        #1 chk("mult_hi", 64'(hi_o), 64'h1);
        chk("mult_lo", 64'(lo_o), 64'hFFFFFFFE);
        cycle();
        set_idle();
        #1 chk("mtlo_lo", 64'(lo_o), 64'h55);
        chk("mtlo_hi", 64'(hi_o), 64'h1);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            resetn       = ($urandom_range(0, 39) != 0);
            wb_memtype   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            wb_mreg      = 1'($urandom);
            wb_whilo     = 2'($urandom);
            wb_wreg      = ($urandom_range(0, 3) != 0);
            wb_wa        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wb_dreg      = $urandom;
            wb_hilo      = {$urandom, $urandom};
            wb_dre       = 4'($urandom);
            wb_pc        = $urandom;
            wb_is_mthilo = 2'($urandom);
            wb_wc0       = 1'($urandom);
            wb_cp0addr   = 5'($urandom);
            wb_cp0wdata  = $urandom;
            wb_daddr     = $urandom;
            dm_rdata     = $urandom;
            trace_ready  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        // overflow: 5 writes with ready low, then drain in order
        set_idle(); resetn = 1'b0; cycle();
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gpr_write(32'h200 + 32'(i * 4), 5'(i + 1), 32'(i));
            cycle();
        end
        set_idle();
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef WB_TRACE_EN
            chk("drain_pc", 64'(trace_pc), 64'(32'h200 + 32'(i * 4)));
            chk("ovf_sticky", 64'(trace_overflow), 64'h1);
`else
            chk("tied_valid", 64'(trace_valid), 64'h0);
`endif
            cycle();
        end
        #1 chk("drained", 64'(trace_valid), 64'h0);

        // full FIFO: push with simultaneous pop
        set_idle(); resetn = 1'b0; cycle();
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gpr_write(32'h300 + 32'(i * 4), 5'(i + 8), 32'hA0 + 32'(i));
            cycle();
        end
        gpr_write(32'h310, 5'd12, 32'hA4);
        trace_ready = 1'b1;
        cycle();
        set_idle();
        wb_whilo = 2'b11; wb_hilo = 64'h12345678_9ABCDEF0;
`ifdef WB_TRACE_EN
        #1 chk("fullpp_valid", 64'(trace_valid), 64'h1);
        chk("fullpp_ovf", 64'(trace_overflow), 64'h0);
        chk("fullpp_head", 64'(trace_pc), 64'h304);
`endif
        cycle();

        // reset mid-drain with 3 entries queued
        gpr_write(32'h400, 5'd7, 32'h77);
        resetn = 1'b0;
        trace_ready = 1'b1;
        #1 chk("pre_rst_hi", 64'(hi_o), 64'h12345678);
        cycle();
        set_idle();
        #1 chk("rst_valid", 64'(trace_valid), 64'h0);
        chk("rst_hi", 64'(hi_o), 64'h0);
        chk("rst_lo", 64'(lo_o), 64'h0);
        chk("rst_ovf", 64'(trace_overflow), 64'h0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
